div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Sequential iterative signed divider; implements MIPS DIV for the multicycle datapath.
- Consumes the A/B register outputs and is started by the control unit's divControl strobe.
- Produces the HI value (remainder) and LO value (quotient) for the HI/LO registers.
- Raises a divide-by-zero flag that feeds the exception-control path (excpCtrl select).

Parameters:
- WIDTH, 32: operand/result width in bits. Iteration count equals WIDTH.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- div_start, input, 1: start strobe from control unit. Sampled only in IDLE.
- a_in, input, WIDTH: dividend (register A).
- b_in, input, WIDTH: divisor (register B).
- hi_out, output, WIDTH: remainder, registered.
- lo_out, output, WIDTH: quotient, registered.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse; hi_out/lo_out valid.
- div_zero, output, 1: one-cycle pulse; divisor was zero.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
- Reset values: hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, state=IDLE, iteration counter=0.
- State machine: IDLE -> RUN -> FIX -> IDLE.
- IDLE, div_start=1, b_in=0:
  - Next cycle div_zero=1 for exactly one cycle.
  - done stays 0; hi_out/lo_out unchanged; stay in IDLE.
- IDLE, div_start=1, b_in!=0:
  - Latch |a_in|, |b_in|, sign_q = a[W-1]^b[W-1], sign_r = a[W-1].
  - Clear partial remainder; counter=WIDTH; busy=1; go to RUN.
- RUN, one restoring step per cycle:
  - rem = {rem[W-2:0], dvd[W-1]}; shift dvd left.
  - If rem >= dvs: rem -= dvs, quotient bit = 1; else quotient bit = 0.
  - Counter decrements; on reaching 0 go to FIX.
  - Internal remainder register is WIDTH+1 bits so no compare overflow occurs.
- FIX:
  - Apply signs: lo_out = sign_q ? -q : q; hi_out = sign_r ? -r : r.
  - Register results; done=1 for one cycle; busy=0; return to IDLE.
- Latency: div_start sampled at edge k -> done and results valid in the cycle after edge k+WIDTH+1, i.e. 34 cycles for WIDTH=32.
- Overflow case, a=0x80000000, b=0xFFFFFFFF: two's-complement wrap gives lo_out=0x80000000, hi_out=0. No flag is raised.
- Absolute value of 0x80000000 is 0x80000000, treated as unsigned magnitude 2^31; the result stays correct.
- div_start while busy=1 is ignored. The in-flight operation is unaffected.
- A new start may be accepted in the same cycle done is high; the FSM is already in IDLE at that point.
- hi_out/lo_out hold their last successful result until the next FIX, or until reset.
- reset mid-operation aborts immediately: all outputs return to reset values and no done pulse is produced.
- a_in/b_in may change after the start cycle; operands are latched.

Optional Feature:
- Macro DIV_UNSIGNED_EN.
- Defined:
  - Adds input port div_unsigned (1 bit), sampled with div_start.
  - When 1, implements DIVU: operands are taken as unsigned, sign_q=sign_r=0, FIX applies no negation.
  - Latency is identical.
- Undefined: port absent; all operations are signed.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=32.
  - The div_state_t enum {IDLE, RUN, FIX}.
  - Exception code constant EXC_DIV_ZERO = 3, used by the excpCtrl mux select logic.
- Natural sub-module: div_step.
  - Combinational single restoring iteration.
  - Inputs: rem, dividend MSB, divisor. Outputs: next rem, quotient bit.
  - Instantiated once inside the RUN datapath.

Test Plan:
- a=100, b=7, start -> after 34 cycles done=1, lo_out=14, hi_out=2; busy high for cycles 1..33.
- a=-100 (0xFFFFFF9C), b=7 -> lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2). Also a=100, b=-7 -> lo=-14, hi=2.
- a=55, b=0 -> div_zero=1 for one cycle next cycle, done never asserts, hi_out/lo_out keep previous values (14/2).
- a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, done after 34 cycles, div_zero=0.
- Start 100/7, assert reset at cycle 10 -> next cycle busy=0, hi_out=lo_out=0, no done pulse. A fresh 9/2 then gives lo=4, hi=1.
- Start 100/7, pulse div_start with 9/3 at cycle 5 -> ignored; result 14/2. A start in the done cycle is accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the multicycle CPU datapath.
//   WORD_W        - datapath word width
//   div_state_t   - divider sequencer states
//   EXC_DIV_ZERO  - exception code driven onto the excpCtrl mux select
//                   when the divider reports a zero divisor
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam logic [3:0] EXC_DIV_ZERO = 4'd3;

endpackage : cpu_pkg

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   rem     - current partial remainder (WIDTH+1 bits)
//   dvdMsb  - dividend bit shifted into the remainder this step
//   dvs     - divisor magnitude
//   remNext - partial remainder after the trial subtraction
//   qBit    - quotient bit produced by this step
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvdMsb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   remNext,
  output logic             qBit
);

  logic [WIDTH+1:0] wide_s;
  logic [WIDTH:0]   low_s;
  logic [WIDTH:0]   dvsExt_s;

  // Shift in the next dividend bit and perform the trial subtraction.
  always_comb begin
    // The compare uses one extra bit so the shifted value can never wrap.
    wide_s   = {rem, dvdMsb};
    low_s    = wide_s[WIDTH:0];
    dvsExt_s = {1'b0, dvs};
    if (wide_s >= {2'b00, dvs}) begin
      remNext = low_s - dvsExt_s;
      qBit    = 1'b1;
    end else begin
      remNext = low_s;
      qBit    = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/div_unit.sv
// div_unit: sequential iterative signed divider (MIPS DIV) for the
// multicycle datapath. One restoring step per cycle, WIDTH steps per op.
// Optional build macro DIV_UNSIGNED_EN adds port div_unsigned for DIVU.
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous active-high reset
//   div_start    - start strobe, honoured only while idle
//   div_unsigned - (DIV_UNSIGNED_EN only) treat operands as unsigned
//   a_in, b_in   - dividend / divisor
//   hi_out       - remainder (registered, holds until next result)
//   lo_out       - quotient  (registered, holds until next result)
//   busy         - operation in progress
//   done         - one-cycle pulse, hi_out/lo_out valid
//   div_zero     - one-cycle pulse, divisor was zero (no result produced)
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  // Two's-complement negate; 0x80..0 maps to itself, read as unsigned 2^(W-1).
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ZERO - v;
  endfunction

  div_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dvd_r;     // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0] dvs_r;
  logic             signQ_r;
  logic             signR_r;

  logic             opSigned_s;
  logic [WIDTH-1:0] absA_s;
  logic [WIDTH-1:0] absB_s;
  logic             signQ_s;
  logic             signR_s;
  logic [WIDTH:0]   stepRem_s;
  logic             stepQ_s;

  // Operand magnitudes and result signs for the operation being started.
  always_comb begin
    opSigned_s = 1'b1;
`ifdef DIV_UNSIGNED_EN
    opSigned_s = ~div_unsigned;
`endif
    if (opSigned_s) begin
      absA_s  = a_in[WIDTH-1] ? negate(a_in) : a_in;
      absB_s  = b_in[WIDTH-1] ? negate(b_in) : b_in;
      signQ_s = a_in[WIDTH-1] ^ b_in[WIDTH-1];
      signR_s = a_in[WIDTH-1];
    end else begin
      absA_s  = a_in;
      absB_s  = b_in;
      signQ_s = 1'b0;
      signR_s = 1'b0;
    end
  end

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (rem_r),
    .dvdMsb  (dvd_r[WIDTH-1]),
    .dvs     (dvs_r),
    .remNext (stepRem_s),
    .qBit    (stepQ_s)
  );

  // Sequencer and datapath registers: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      rem_r    <= {(WIDTH + 1){1'b0}};
      dvd_r    <= ZERO;
      dvs_r    <= ZERO;
      signQ_r  <= 1'b0;
      signR_r  <= 1'b0;
      hi_out   <= ZERO;
      lo_out   <= ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_r)
        IDLE: begin
          if (div_start) begin
            if (b_in == ZERO) begin
              div_zero <= 1'b1;
            end else begin
              dvd_r   <= absA_s;
              dvs_r   <= absB_s;
              signQ_r <= signQ_s;
              signR_r <= signR_s;
              rem_r   <= {(WIDTH + 1){1'b0}};
              cnt_r   <= CNT_INIT;
              busy    <= 1'b1;
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          rem_r <= stepRem_s;
          dvd_r <= {dvd_r[WIDTH-2:0], stepQ_s};
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          lo_out  <= signQ_r ? negate(dvd_r) : dvd_r;
          hi_out  <= signR_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH = 32).
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef DIV_UNSIGNED_EN
  logic        div_unsigned;
`endif

  int nVec;
  int nErr;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned (div_unsigned),
`endif
    .a_in         (a_in),
    .b_in         (b_in),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: starts a division, scrambles the operand inputs afterwards,
  // then waits (bounded) for done. lat = negedges from start-accept to done.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busyCnt, output int dzCnt);
    @(negedge clk);
    a_in = a; b_in = b; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    a_in = 32'hDEAD_BEEF; b_in = 32'h0000_0000;
    lat = 0; busyCnt = 0; dzCnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyCnt++;
      if (div_zero === 1'b1) dzCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; div_start = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (2) @(negedge clk);
    nVec++;
    if ({hi_out, lo_out, busy, done, div_zero} !== 67'd0) begin
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, expected all zero",
               hi_out, lo_out, busy, done, div_zero);
      nErr++;
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc, dz;
    run_div(32'd100, 32'd7, lat, bc, dz);
    nVec++;
    if (lat !== 33) begin $display("FAIL basic_latency: got %0d expected 33", lat); nErr++; end
    nVec++;
    if (bc !== 33) begin $display("FAIL basic_busy_cycles: got %0d expected 33", bc); nErr++; end
    nVec++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      $display("FAIL basic_100_7: got lo=%0d hi=%0d expected lo=14 hi=2", lo_out, hi_out); nErr++;
    end
    nVec++;
    if (busy !== 1'b0) begin $display("FAIL basic_busy_at_done: got %b expected 0", busy); nErr++; end
    @(negedge clk);
    nVec++;
    if (done !== 1'b0) begin $display("FAIL basic_done_pulse: got %b expected 0", done); nErr++; end
  endtask

  task automatic test_signed();
    int lat, bc, dz;
    run_div(32'hFFFF_FF9C, 32'd7, lat, bc, dz);
    nVec++;
    if (lo_out !== 32'hFFFF_FFF2 || hi_out !== 32'hFFFF_FFFE) begin
      $display("FAIL signed_neg100_7: got lo=%h hi=%h expected lo=fffffff2 hi=fffffffe", lo_out, hi_out); nErr++;
    end
    run_div(32'd100, 32'hFFFF_FFF9, lat, bc, dz);
    nVec++;
    if (lo_out !== 32'hFFFF_FFF2 || hi_out !== 32'd2) begin
      $display("FAIL signed_100_neg7: got lo=%h hi=%h expected lo=fffffff2 hi=00000002", lo_out, hi_out); nErr++;
    end
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bc, dz);
    nVec++;
    if (lo_out !== 32'd14 || hi_out !== 32'hFFFF_FFFE) begin
      $display("FAIL signed_neg100_neg7: got lo=%h hi=%h expected lo=0000000e hi=fffffffe", lo_out, hi_out); nErr++;
    end
    // Restore 14/2 as the held result for the divide-by-zero test.
    run_div(32'd100, 32'd7, lat, bc, dz);
  endtask

  task automatic test_div_zero();
    int dzCnt, doneCnt;
    @(negedge clk);
    a_in = 32'd55; b_in = 32'd0; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    nVec++;
    if (div_zero !== 1'b1) begin $display("FAIL divzero_flag: got %b expected 1", div_zero); nErr++; end
    nVec++;
    if (busy !== 1'b0) begin $display("FAIL divzero_busy: got %b expected 0", busy); nErr++; end
    dzCnt = 0; doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_zero === 1'b1) dzCnt++;
      if (done === 1'b1) doneCnt++;
    end
    nVec++;
    if (dzCnt !== 0 || doneCnt !== 0) begin
      $display("FAIL divzero_pulses: got extra dz=%0d done=%0d expected 0/0", dzCnt, doneCnt); nErr++;
    end
    nVec++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      $display("FAIL divzero_hold: got lo=%0d hi=%0d expected lo=14 hi=2", lo_out, hi_out); nErr++;
    end
  endtask

  task automatic test_overflow();
    int lat, bc, dz;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
    nVec++;
    if (lo_out !== 32'h8000_0000 || hi_out !== 32'd0 || lat !== 33) begin
      $display("FAIL overflow: got lo=%h hi=%h lat=%0d expected lo=80000000 hi=0 lat=33", lo_out, hi_out, lat); nErr++;
    end
    nVec++;
    if (dz !== 0 || div_zero !== 1'b0) begin $display("FAIL overflow_flag: got dz=%0d expected 0", dz); nErr++; end
    run_div(32'h8000_0000, 32'd3, lat, bc, dz);
    nVec++;
    if (lo_out !== 32'hD555_5556 || hi_out !== 32'hFFFF_FFFE) begin
      $display("FAIL minint_div3: got lo=%h hi=%h expected lo=d5555556 hi=fffffffe", lo_out, hi_out); nErr++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dz, doneCnt;
    @(negedge clk);
    a_in = 32'd100; b_in = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nVec++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || done !== 1'b0) begin
      $display("FAIL midreset_state: got busy=%b hi=%h lo=%h done=%b expected 0", busy, hi_out, lo_out, done); nErr++;
    end
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    nVec++;
    if (doneCnt !== 0) begin $display("FAIL midreset_no_done: got %0d done pulses expected 0", doneCnt); nErr++; end
    run_div(32'd9, 32'd2, lat, bc, dz);
    nVec++;
    if (lo_out !== 32'd4 || hi_out !== 32'd1) begin
      $display("FAIL midreset_fresh: got lo=%0d hi=%0d expected lo=4 hi=1", lo_out, hi_out); nErr++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a_in = 32'd100; b_in = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 4) begin a_in = 32'd9; b_in = 32'd3; div_start = 1'b1; end
      else div_start = 1'b0;
      @(negedge clk);
      lat++;
    end
    div_start = 1'b0;
    nVec++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2 || lat !== 33) begin
      $display("FAIL ignore_busy_start: got lo=%0d hi=%0d lat=%0d expected 14/2 lat=33", lo_out, hi_out, lat); nErr++;
    end
    // Start in the done cycle.
    a_in = 32'd9; b_in = 32'd2; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    nVec++;
    if (busy !== 1'b1) begin $display("FAIL done_cycle_accept: got busy=%b expected 1", busy); nErr++; end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    nVec++;
    if (lo_out !== 32'd4 || hi_out !== 32'd1 || lat !== 33) begin
      $display("FAIL done_cycle_result: got lo=%0d hi=%0d lat=%0d expected 4/1 lat=33", lo_out, hi_out, lat); nErr++;
    end
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
`ifdef DIV_UNSIGNED_EN
    div_unsigned = 1'b0;
`endif
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule : tb_div_unit
